vga_scan_gen: RTL and testbench
===============================

// Module: vga_scan_gen
// PURPOSE
//  Source end of the pixel-coordinate interface consumed by the text/sprite renderers (x, y -> display).
//  Divides the system clock to a pixel tick and runs horizontal/vertical scan counters.
//  Emits x, y, video_on, hsync, vsync and frame/line strobes to the renderers and the VGA pins.
//  One instance per design, sitting between the clock source and all draw logic.
// PARAMETERS
//  CLK_DIV    4    system clocks per pixel (>=1); 100 MHz -> 25 MHz
//  H_DISPLAY  640  visible pixels per line
//  H_FRONT    16   horizontal front porch, pixels
//  H_SYNC     96   hsync pulse width, pixels
//  H_BACK     48   horizontal back porch, pixels
//  V_DISPLAY  480  visible lines per frame
//  V_FRONT    10   vertical front porch, lines
//  V_SYNC     2    vsync pulse width, lines
//  V_BACK     33   vertical back porch, lines
//  SYNC_POL   0    sync active level (0 = active-low)
//  COORD_W    10   width of x/y; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous, active-low reset
//  en           in   1        scan enable; low freezes divider, counters and outputs
//  x            out  COORD_W  current horizontal count, 0..H_TOTAL-1
//  y            out  COORD_W  current vertical count, 0..V_TOTAL-1
//  video_on     out  1        high when x<H_DISPLAY and y<V_DISPLAY
//  hsync        out  1        horizontal sync, level per SYNC_POL
//  vsync        out  1        vertical sync, level per SYNC_POL
//  pixel_tick   out  1        1-clk strobe, once per pixel period
//  line_start   out  1        1-clk strobe when x becomes 0
//  frame_start  out  1        1-clk strobe when (x,y) becomes (0,0)
// BEHAVIOUR
//  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
//  - Reset (async assert, sync release): div=0, h=0, v=0; x=y=0, video_on=0, pixel_tick=0,
//    line_start=0, frame_start=0, hsync=vsync=~SYNC_POL (inactive).
//  - Divider: div counts 0..CLK_DIV-1 while en=1; tick_int=1 when div==CLK_DIV-1, div then wraps to 0.
//    CLK_DIV=1: tick_int every clock.
//  - On tick_int: h<=h+1; h==H_TOTAL-1 -> h<=0 and v advances; v==V_TOTAL-1 at h wrap -> v<=0.
//  - All outputs registered from next-state counter values: x,y,video_on,syncs change on the same
//    edge as h/v; pixel_tick, line_start, frame_start high for exactly that one clock.
//  - hsync active iff H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC (656..751).
//  - vsync active iff V_DISPLAY+V_FRONT <= v < V_DISPLAY+V_FRONT+V_SYNC (490..491); vsync follows v,
//    so it switches at the h wrap.
//  - x/y not clamped in blanking; renderers gate on video_on.
//  - en=0: div, h, v and all level outputs hold; strobes forced 0. Resume continues from the held div.
//  - Simultaneous h and v wrap: single cycle, frame_start and line_start both asserted.
//  - Reset mid-line/mid-frame: all state returns to reset values immediately; first tick after release
//    moves to (1,0), so the first frame_start comes after one full frame.
//  - Arithmetic: unsigned, comparisons against parameter-derived localparams of width COORD_W.
// STRUCTURE
//  - Package vga_timing_pkg: 640x480@60 timing constants, H_TOTAL/V_TOTAL derivation, COORD_W default.
//  - Sub-module pixel_tick_div (clk, rst_n, en -> tick), parameter CLK_DIV.
//  - Top: scan counters, sync/video decode, output registers.
// TESTING
//  - Reset: hold rst_n=0 20 clks -> x=y=0, video_on=0, hsync=vsync=1, all strobes 0.
//  - Tick rate: CLK_DIV=4, en=1 -> pixel_tick every 4th clk; x increments 0,1,2 per tick.
//  - Line timing: hsync low exactly 96 ticks from x=656; video_on falls at x=640; line_start at x=0 every 800 ticks.
//  - Frame wrap: at (799,524) next tick -> (0,0), frame_start and line_start both 1 for one clk; vsync low for y=490..491.
//  - Enable: en=0 at x=100 for 50 clks -> x stays 100, no strobes; en=1 -> x=101 after remaining div count.
//  - Mid-frame reset: rst_n low at (300,200) -> outputs to reset values without waiting for clk; restart from (0,0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants shared by the scan generator and its users.
package vga_timing_pkg;
  localparam int CLK_DIV_DEF   = 4;
  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int COORD_W_DEF   = 10;

  function automatic int scan_total(int disp, int front, int sync, int back);
    return disp + front + sync + back;
  endfunction

  localparam int H_TOTAL_DEF = scan_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = scan_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);
endpackage

// File: rtl/vga_scan_gen_if.sv
// Pixel-coordinate bus from the scan generator to renderers and VGA pins.
interface vga_scan_if #(parameter int COORD_W = vga_timing_pkg::COORD_W_DEF);
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               video_on;
    logic               hsync;
    logic               vsync;
    logic               pixel_tick;
    logic               line_start;
    logic               frame_start;

    modport master (output x, y, video_on, hsync, vsync, pixel_tick, line_start, frame_start);
    modport slave  (input  x, y, video_on, hsync, vsync, pixel_tick, line_start, frame_start);
endinterface

// File: rtl/pixel_tick_div.sv
// Divides the system clock down to a one-clock pixel tick; freezes while en is low.
module pixel_tick_div #(
    parameter int CLK_DIV = vga_timing_pkg::CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    // Combinational so the scan counters advance on the same edge div wraps.
    assign tick = en && (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (en) begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end
    end
endmodule

// File: rtl/vga_scan_gen.sv
// Horizontal/vertical scan counters with registered sync, video and strobe outputs.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter bit SYNC_POL  = 1'b0,
    parameter int COORD_W   = COORD_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    vga_scan_if.master scan
);
    localparam int H_TOTAL = scan_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = scan_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC);

    logic               tick;
    logic [COORD_W-1:0] h, v, h_nxt, v_nxt;

    pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .tick (tick)
    );

    always_comb begin
        h_nxt = h + 1'b1;
        v_nxt = v;
        if (h == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
        end
    end

    // Decode from next-state values so every output moves on the same edge as h/v.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h                <= '0;
            v                <= '0;
            scan.video_on    <= 1'b0;
            scan.hsync       <= !SYNC_POL;
            scan.vsync       <= !SYNC_POL;
            scan.pixel_tick  <= 1'b0;
            scan.line_start  <= 1'b0;
            scan.frame_start <= 1'b0;
        end else begin
            scan.pixel_tick  <= tick;
            scan.line_start  <= tick && (h_nxt == '0);
            scan.frame_start <= tick && (h_nxt == '0) && (v_nxt == '0);
            if (tick) begin
                h             <= h_nxt;
                v             <= v_nxt;
                scan.video_on <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
                scan.hsync    <= ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? SYNC_POL : !SYNC_POL;
                scan.vsync    <= ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? SYNC_POL : !SYNC_POL;
            end
        end
    end

    assign scan.x = h;
    assign scan.y = v;
endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench: a pixel-count model predicts each tick's outputs; a monitor checks them.
module tb_vga_scan_gen;
    localparam int D  = 3;
    localparam int HD = 20, HF = 3, HS = 4, HB = 5;
    localparam int VD = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int CW = 6;
    localparam bit POL = 1'b0;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic vid, hs, vs, pt, ls, fs;
    } obs_t;

    localparam obs_t RST = '{x: '0, y: '0, vid: 1'b0, hs: !POL, vs: !POL, pt: 1'b0, ls: 1'b0, fs: 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n = 0;
    obs_t q[$];

    vga_scan_if #(.COORD_W(CW)) scan ();

    vga_scan_gen #(
        .CLK_DIV(D), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(POL), .COORD_W(CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .scan (scan)
    );

    always #5 clk = ~clk;

    // Pixel p (counted from reset) sits at x = p mod HT on line (p div HT) mod VT.
    function automatic obs_t exp_at(int p);
        int xx, yy;
        obs_t o;
        xx    = p % HT;
        yy    = (p / HT) % VT;
        o.x   = CW'(xx);
        o.y   = CW'(yy);
        o.vid = (xx < HD) && (yy < VD);
        o.hs  = (xx >= HD + HF && xx < HD + HF + HS) ? POL : !POL;
        o.vs  = (yy >= VD + VF && yy < VD + VF + VS) ? POL : !POL;
        o.pt  = 1'b1;
        o.ls  = (xx == 0);
        o.fs  = (xx == 0) && (yy == 0);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{x: scan.x, y: scan.y, vid: scan.video_on, hs: scan.hsync, vs: scan.vsync,
              pt: scan.pixel_tick, ls: scan.line_start, fs: scan.frame_start};
        return o;
    endfunction

    task automatic cmp(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got x=%0d y=%0d vid=%b hs=%b vs=%b pt=%b ls=%b fs=%b want x=%0d y=%0d vid=%b hs=%b vs=%b pt=%b ls=%b fs=%b",
                     name, act.x, act.y, act.vid, act.hs, act.vs, act.pt, act.ls, act.fs,
                     exp.x, exp.y, exp.vid, exp.hs, exp.vs, exp.pt, exp.ls, exp.fs);
        end
    endtask

    // One stimulus clock: drive en and let the model predict any tick it causes.
    task automatic step(input logic e);
        @(posedge clk);
        #1;
        en = e;
        if (rst_n && e) begin
            n++;
            if (n % D == 0) q.push_back(exp_at(n / D));
        end
    endtask

    task automatic do_reset(input int clks);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        en = 1'b0;
        q.delete();
        n = 0;
        #1;
        cmp("async_reset", sample(), RST);
        repeat (clks) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pop on every tick, otherwise levels must hold and strobes stay low.
    initial begin
        obs_t held, e, a;
        held = RST;
        forever begin
            @(negedge clk);
            a = sample();
            if (!rst_n) begin
                held = RST;
                cmp("reset_state", a, RST);
            end else if (a.pt) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_tick got x=%0d y=%0d want no tick", a.x, a.y);
                end else begin
                    e = q.pop_front();
                    cmp("tick", a, e);
                    held = e;
                    held.pt = 1'b0;
                    held.ls = 1'b0;
                    held.fs = 1'b0;
                end
            end else begin
                checks++;
                if (q.size() > 1) begin
                    errors++;
                    $display("FAIL missed_tick got pending=%0d want <=1", q.size());
                    void'(q.pop_front());
                end
                cmp("hold", a, held);
            end
        end
    end

    initial begin
        // Reset held for 20 clocks, then free-run and an enable pause of 50 clocks.
        rst_n = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (200) step(1'b1);
        repeat (50) step(1'b0);
        repeat (100) step(1'b1);
        // Random enable long enough to cross several frame wraps.
        repeat (6000) step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0);
        do_reset(3);
        repeat (2500) step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        do_reset($urandom_range(1, 5));
        repeat (2200) step(1'b1);
        repeat (6) step(1'b0);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
